// File: rtl/fir_pkg.sv
// Shared types and width helpers for the programmable transposed FIR.
package fir_pkg;

  // Coefficient bank commit states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SETTLE  = 2'd2
  } fir_state_e;

  // Full-precision accumulator width for NTAPS products of DATA_W x COEF_W.
  function automatic int unsigned acc_width(input int unsigned data_w,
                                            input int unsigned coef_w,
                                            input int unsigned ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_tap.sv
// One transposed FIR stage: active coefficient register, multiply, add, s register.
module fir_tap #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 18,
  parameter int unsigned ACC_W  = 37
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              load_i,
  input  logic [COEF_W-1:0] coef_i,
  input  logic [DATA_W-1:0] x_i,
  input  logic [ACC_W-1:0]  s_i,
  output logic [ACC_W-1:0]  s_o
);

  localparam int unsigned PROD_W = DATA_W + COEF_W;

  logic [COEF_W-1:0]        h_q, h_d;
  logic [ACC_W-1:0]         s_q, s_d;
  logic signed [PROD_W-1:0] prod_c;

  // Multiply-add on accepted samples; coefficient changes only on a bank load.
  always_comb begin
    prod_c = PROD_W'($signed(h_q)) * PROD_W'($signed(x_i));
    h_d    = load_i ? coef_i : h_q;
    s_d    = en_i ? ACC_W'(prod_c) + s_i : s_q;
  end

  // Stage registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      s_q <= '0;
    end else begin
      h_q <= h_d;
      s_q <= s_d;
    end
  end

  assign s_o = s_q;

endmodule

// File: rtl/fir_pgm_transposed.sv
// Transposed-form FIR with double-buffered, runtime-programmable coefficients.
// Optional FIR_ROUND_SAT_EN: round half-up at OUT_SHIFT-1 and saturate out_o
// instead of the plain wrapping slice.
module fir_pgm_transposed
  import fir_pkg::*;
#(
  parameter int unsigned NTAPS     = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned COEF_W    = 18,
  parameter int unsigned OUT_W     = 24,
  parameter int unsigned OUT_SHIFT = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [DATA_W-1:0]        in_i,
  input  logic                     in_valid_i,
  input  logic                     coef_wr_i,
  input  logic [$clog2(NTAPS)-1:0] coef_addr_i,
  input  logic [COEF_W-1:0]        coef_dat_i,
  input  logic                     coef_commit_i,
  output logic                     coef_ack_o,
  output logic                     coef_busy_o,
  output logic [OUT_W-1:0]         out_o,
  output logic                     out_valid_o,
  output logic                     out_settled_o
);

  localparam int unsigned ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);
  localparam int unsigned ADDR_W = $clog2(NTAPS);
  localparam int unsigned CNT_W  = ADDR_W;
  localparam int unsigned PROD_W = DATA_W + COEF_W;
  localparam int unsigned EXT_W  = ACC_W + OUT_W + OUT_SHIFT + 2;

  // Sample pipeline
  logic [DATA_W-1:0]        x_q, x_d;
  logic                     v0_q, v0_d;
  logic                     v1_q, v1_d;
  logic [ACC_W-1:0]         acc_q, acc_d;
  logic [COEF_W-1:0]        h0_q, h0_d;
  logic                     set1_q, set1_d;
  logic signed [PROD_W-1:0] prod0_c;
  logic [ACC_W-1:0]         s_w [1:NTAPS];

  // Coefficient control
  logic [COEF_W-1:0]        shadow_q [NTAPS];
  logic [COEF_W-1:0]        shadow_d [NTAPS];
  fir_state_e               state_q, state_d;
  logic [CNT_W-1:0]         settle_cnt_q, settle_cnt_d;
  logic                     ack_q, ack_d;
  logic                     busy_q, busy_d;
  logic                     wr_ok_c;
  logic                     load_c;

  // Output stage
  logic [OUT_W-1:0]         out_q, out_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_settled_q, out_settled_d;
  logic [EXT_W-1:0]         acc_ext_c;
  logic [OUT_W-1:0]         slice_c;
  logic                     unused_ext_c;

  // The bank swap happens only on an edge with no sample entering the taps.
  assign load_c = (state_q == PENDING) && !v0_q;

  // Input capture and the tap-0 accumulator stage.
  always_comb begin
    x_d     = in_valid_i ? in_i : x_q;
    v0_d    = in_valid_i;
    v1_d    = v0_q;
    h0_d    = load_c ? shadow_q[0] : h0_q;
    prod0_c = PROD_W'($signed(h0_q)) * PROD_W'($signed(x_q));
    acc_d   = v0_q ? ACC_W'(prod0_c) + s_w[1] : acc_q;
    set1_d  = v0_q ? (settle_cnt_q == '0) : set1_q;
  end

  assign s_w[NTAPS] = '0;

  // Taps 1..NTAPS-1 feed the partial-sum chain toward the accumulator.
  for (genvar k = 1; k < NTAPS; k++) begin : g_tap
    fir_tap #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W)
    ) u_tap (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (v0_q),
      .load_i (load_c),
      .coef_i (shadow_q[k]),
      .x_i    (x_q),
      .s_i    (s_w[k+1]),
      .s_o    (s_w[k])
    );
  end

  // Shadow writes, commit state machine and settle counter.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    shadow_d     = shadow_q;
    wr_ok_c      = coef_wr_i && (32'(coef_addr_i) < NTAPS) && (state_q != PENDING);
    ack_d        = wr_ok_c;

    for (int unsigned k = 0; k < NTAPS; k++) begin
      if (wr_ok_c && (coef_addr_i == ADDR_W'(k))) begin
        shadow_d[k] = coef_dat_i;
      end
    end

    // Every accepted sample retires one mixed-coefficient output.
    if (v0_q && (settle_cnt_q != '0)) begin
      settle_cnt_d = settle_cnt_q - CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (coef_commit_i) state_d = PENDING;
      end
      PENDING: begin
        if (!v0_q) begin
          state_d      = SETTLE;
          settle_cnt_d = CNT_W'(NTAPS - 1);
        end
      end
      SETTLE: begin
        if (coef_commit_i)            state_d = PENDING;
        else if (settle_cnt_d == '0)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == PENDING);
  end

  // Accumulator slice to the output width, wrapping or rounded/saturated.
  always_comb begin
    acc_ext_c = EXT_W'($signed(acc_q));
    slice_c   = acc_ext_c[OUT_SHIFT +: OUT_W];
  end

`ifdef FIR_ROUND_SAT_EN
  localparam logic [EXT_W-1:0]        RND_ONE = (EXT_W'(1) << OUT_SHIFT) >> 1;
  localparam logic signed [EXT_W-1:0] OUT_MAX = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] OUT_MIN = ~OUT_MAX;

  logic signed [EXT_W-1:0] rnd_c;
  logic signed [EXT_W-1:0] clamp_c;

  // Round half-up at the dropped LSBs, then clamp to the signed output range.
  always_comb begin
    rnd_c   = $signed(acc_ext_c + RND_ONE) >>> OUT_SHIFT;
    clamp_c = rnd_c;
    if (rnd_c > OUT_MAX)      clamp_c = OUT_MAX;
    else if (rnd_c < OUT_MIN) clamp_c = OUT_MIN;
  end

  assign unused_ext_c = ^{clamp_c[EXT_W-1:OUT_W], slice_c};

  // Output register update on each result.
  always_comb begin
    out_d         = v1_q ? clamp_c[OUT_W-1:0] : out_q;
    out_valid_d   = v1_q;
    out_settled_d = v1_q ? set1_q : out_settled_q;
  end
`else
  // Extension bits above and below the slice are dropped on purpose.
  assign unused_ext_c = ^acc_ext_c;

  // Output register update on each result.
  always_comb begin
    out_d         = v1_q ? slice_c : out_q;
    out_valid_d   = v1_q;
    out_settled_d = v1_q ? set1_q : out_settled_q;
  end
`endif

  // All state registers; reset loads the impulse response into the active bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q           <= '0;
      v0_q          <= 1'b0;
      v1_q          <= 1'b0;
      acc_q         <= '0;
      h0_q          <= COEF_W'(1);
      set1_q        <= 1'b1;
      shadow_q      <= '{default: '0};
      state_q       <= IDLE;
      settle_cnt_q  <= '0;
      ack_q         <= 1'b0;
      busy_q        <= 1'b0;
      out_q         <= '0;
      out_valid_q   <= 1'b0;
      out_settled_q <= 1'b1;
    end else begin
      x_q           <= x_d;
      v0_q          <= v0_d;
      v1_q          <= v1_d;
      acc_q         <= acc_d;
      h0_q          <= h0_d;
      set1_q        <= set1_d;
      shadow_q      <= shadow_d;
      state_q       <= state_d;
      settle_cnt_q  <= settle_cnt_d;
      ack_q         <= ack_d;
      busy_q        <= busy_d;
      out_q         <= out_d;
      out_valid_q   <= out_valid_d;
      out_settled_q <= out_settled_d;
    end
  end

  assign coef_ack_o    = ack_q;
  assign coef_busy_o   = busy_q;
  assign out_o         = out_q;
  assign out_valid_o   = out_valid_q;
  assign out_settled_o = out_settled_q;

endmodule

// File: doc/fir_pgm_transposed.md
# fir_pgm_transposed

Parametrised transposed-form FIR filter with runtime-programmable, double-buffered coefficients. It is the DSP48E2-mapped successor to the fixed-coefficient single-slice core: NTAPS multiply-add stages, gap-tolerant sample valid, and a coefficient commit state machine that swaps banks safely and flags outputs computed with mixed coefficient sets. It sits between a sample source and any downstream decimator or trigger logic.

## Interface
- NTAPS, 8, tap count, 2..32
- DATA_W, 16, signed input width, ≤26
- COEF_W, 18, signed coefficient width, ≤18
- OUT_W, 24, output width
- OUT_SHIFT, 0, LSB index of the accumulator slice driven to out_o
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-high
- in_i  in  DATA_W  signed sample
- in_valid_i  in  1  sample strobe; gaps allowed
- coef_wr_i  in  1  shadow-bank write strobe
- coef_addr_i  in  $clog2(NTAPS)  tap index
- coef_dat_i  in  COEF_W  signed coefficient
- coef_commit_i  in  1  request shadow→active bank swap
- coef_ack_o  out  1  pulse: write accepted
- coef_busy_o  out  1  commit pending
- out_o  out  OUT_W  filtered sample
- out_valid_o  out  1  one-cycle strobe per accepted sample
- out_settled_o  out  1  out_o used a single coefficient set

## Operation
- ACC_W = DATA_W + COEF_W + $clog2(NTAPS); all sums full precision, signed.
- Stage 0: x_q <= in_i, v0 <= in_valid_i (x_q loads only when in_valid_i).
- On edges with v0=1: s[k] <= h[k]·x_q + s[k+1] for k=1..NTAPS-1 (s[NTAPS]=0); acc <= h[0]·x_q + s[1]. s[] and acc hold when v0=0.
- Result: acc = Σ h[k]·x[n-k] over accepted samples, independent of gaps.
- out_o = acc[OUT_SHIFT +: OUT_W] (see Configuration).
- Coefficient writes: coef_wr_i with coef_addr_i < NTAPS and state ≠ PENDING writes shadow[addr]; coef_ack_o pulses next cycle. Out-of-range address or PENDING: ignored, no ack.
- States: IDLE, PENDING, SETTLE.
  - IDLE/SETTLE + coef_commit_i → PENDING.
  - PENDING: at first edge with v0=0, active <= shadow, settle_cnt <= NTAPS-1 → SETTLE.
  - SETTLE: each v0 edge decrements settle_cnt; at 0 → IDLE.
- out_settled_o is registered with out_valid_o: 1 iff settle_cnt was 0 at that v0 edge. Exactly NTAPS-1 outputs after a swap carry out_settled_o=0.
- Commit while PENDING: no effect. coef_wr_i and coef_commit_i in the same cycle: the write lands first, the commit includes it.
- coef_busy_o = (state == PENDING).

## Timing
- Latency: in_valid_i at edge t → out_valid_o high for the cycle following edge t+2; out_o holds until the next output.
- Reset values: x_q, s[], acc, out_o = 0; v0, out_valid_o, coef_ack_o, coef_busy_o = 0; out_settled_o = 1; state IDLE; shadow = 0; active = impulse (h[0]=1, others 0), so reset behaviour is a 2-cycle pass-through with OUT_SHIFT=0.
- Reset mid-PENDING/SETTLE aborts the swap; active returns to the impulse.
- Sustained in_valid_i=1 delays a pending swap indefinitely; coef_busy_o stays high.

## Configuration
- FIR_ROUND_SAT_EN defined: out_o = acc rounded half-up at bit OUT_SHIFT-1 (none when OUT_SHIFT=0), then saturated to the signed OUT_W range.
- Undefined: plain truncation/wrap slice acc[OUT_SHIFT +: OUT_W].

## Structure
- Package fir_pkg: state enum (IDLE, PENDING, SETTLE), function acc_width(DATA_W, COEF_W, NTAPS).
- Sub-module fir_tap: one transposed stage (coefficient register, multiply, add, s register with enable), generated NTAPS-1 times. The active coefficient stays a registered input so DSP48E2 inference holds.

## Test plan
- Reset, then in_i = 5, −3, 7 back-to-back → out_o = 5, −3, 7, two cycles later, out_settled_o=1.
- Write h = 1..8, commit with idle input, impulse 1 followed by zeros with random gaps → out_o = 1,2,…,8 then 0; first 7 outputs after the swap show out_settled_o=0.
- Commit during continuous in_valid_i for 20 cycles → coef_busy_o high throughout; swap on the first gap; write during PENDING gets no ack and the shadow is unchanged.
- coef_addr_i = NTAPS (NTAPS=6) → no ack, shadow unchanged.
- FIR_ROUND_SAT_EN, OUT_W=16, h[0]=2, in_i = 0x7FFF → out_o = 0x7FFF (saturated); without the macro → 0xFFFE.
- rst_i asserted while PENDING → coef_busy_o = 0 and impulse pass-through after release.
